// File: rtl/uart_tx_frame.sv
// Purpose : UART serial transmitter: start bit, 5-8 data bits LSB first, optional parity, 1/1.5/2-bit stop.
// Latency : tx falls on the edge after accept; tx_done is a pulse div_l*(16*(1+N+P)+S) clocks after accept.
// Backpr.  : valid/ready; tx_ready is low for the whole frame, so tx_valid while busy is ignored.
//
// Ports:
//   clock, reset_n                           - system clock, asynchronous active-low reset
//   bps_div, data_size, stop_size, parity_check - line configuration, latched at accept
//   tx_data, tx_valid, tx_ready              - byte handshake
//   tx, tx_busy, tx_done                     - serial line, frame-in-progress flag, end-of-frame pulse
module uart_tx_frame #(
  parameter int OVERSAMPLE = 16,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] bps_div,
  input  logic [3:0]  data_size,
  input  logic [5:0]  stop_size,
  input  logic [1:0]  parity_check,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx,
  output logic        tx_busy,
  output logic        tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [5:0] OS_LAST = 6'(OVERSAMPLE - 1);
  localparam logic [5:0] OS_BITS = 6'(OVERSAMPLE);

  state_t      state;
  logic [7:0]  data_l;
  logic [15:0] div_l;
  logic [3:0]  nbits;
  logic [5:0]  stop_l;
  logic [1:0]  par_l;
  logic [15:0] div_cnt;
  logic [5:0]  tick_cnt;
  logic [2:0]  bit_idx;

  logic        accept;
  logic        tick;
  logic        par_en;
  logic        par_bit;
  logic        par_x;
  logic [3:0]  ds_c;
  logic [5:0]  ss_c;
  logic [15:0] bd_c;

  // Configuration clamping applied to the values being latched.
  always_comb begin
    ds_c = (data_size < 4'd5) ? 4'd5 : ((data_size > 4'd8) ? 4'd8 : data_size);
    ss_c = (stop_size == 6'd0) ? OS_BITS : stop_size;
    bd_c = (bps_div < 16'd2) ? 16'd1 : bps_div;
  end

  always_comb begin
    accept = tx_valid && tx_ready;
    // div_l is never 0, so div_l-1 cannot wrap; div_l==1 ticks every clock.
    tick   = tx_busy && (div_cnt == div_l - 16'd1);
    par_en = (par_l == 2'b01) || (par_l == 2'b10);
  end

  // Parity covers only the nbits data bits actually sent; odd parity inverts.
  always_comb begin
    par_x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(nbits)) par_x = par_x ^ data_l[i];
    end
    par_bit = (par_l == 2'b01) ? ~par_x : par_x;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      data_l   <= 8'd0;
      div_l    <= 16'd1;
      nbits    <= 4'd8;
      stop_l   <= OS_BITS;
      par_l    <= 2'b00;
      div_cnt  <= 16'd0;
      tick_cnt <= 6'd0;
      bit_idx  <= 3'd0;
      tx       <= IDLE_LEVEL;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (tx_busy) begin
        div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          tx <= IDLE_LEVEL;
          if (accept) begin
            data_l   <= tx_data;
            div_l    <= bd_c;
            nbits    <= ds_c;
            stop_l   <= ss_c;
            par_l    <= parity_check;
            div_cnt  <= 16'd0;
            tick_cnt <= 6'd0;
            bit_idx  <= 3'd0;
            tx       <= ~IDLE_LEVEL;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= 6'd0;
              bit_idx  <= 3'd0;
              tx       <= data_l[0];
              state    <= DATA;
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= 6'd0;
              if ({1'b0, bit_idx} == nbits - 4'd1) begin
                if (par_en) begin
                  tx    <= par_bit;
                  state <= PARITY;
                end else begin
                  tx    <= IDLE_LEVEL;
                  state <= STOP;
                end
              end else begin
                bit_idx <= bit_idx + 3'd1;
                tx      <= data_l[bit_idx + 3'd1];
              end
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end

        PARITY: begin
          if (tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= 6'd0;
              tx       <= IDLE_LEVEL;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end

        STOP: begin
          if (tick) begin
            // stop_l may be 24 (1.5 bits), so the stop period is counted in ticks.
            if (tick_cnt == stop_l - 6'd1) begin
              tick_cnt <= 6'd0;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 6'd1;
            end
          end
        end

        default: begin
          tx    <= IDLE_LEVEL;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
